// File: rtl/alarm_trigger.sv
// Alarm/chime trigger: compares BCD time to the alarm setting, runs the snooze/re-ring FSM, emits chime and alarm start pulses.
// Latency: every output is registered one CP_1Hz tick after the inputs are sampled. No backpressure; tick-driven only.
// Optional feature: define HOURLY_CHIME_EN to build the hourly chime path; otherwise start_light_hour/show_hour are tied low.
module alarm_trigger #(
    parameter int RING_SEC   = 31,
    parameter int SNOOZE_SEC = 300,
    parameter int SNOOZE_MAX = 3
) (
    input  logic       CP_1Hz,
    input  logic       _CR,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    input  logic       alarm_key,
    input  logic       snooze_key,
    output logic       start_light_hour,
    output logic [7:0] show_hour,
    output logic       start_light_alarm,
    output logic       active_alarm
);

    localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam int PW = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1;

    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC - 1);
    localparam logic [PW-1:0] REP_MAX   = PW'(SNOOZE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            en, en_nxt;
    logic            alarm_key_q, snooze_key_q;
    logic            alarm_rise, snooze_rise, match;
    logic [RW-1:0]   ring_cnt, ring_cnt_nxt;
    logic [SW-1:0]   snz_cnt, snz_cnt_nxt;
    logic [PW-1:0]   rep, rep_nxt;
    logic            start_alarm_nxt, active_nxt;

    assign alarm_rise  = alarm_key & ~alarm_key_q;
    assign snooze_rise = snooze_key & ~snooze_key_q;

    // Match uses the pre-toggle enable so a same-tick key press cannot arm and fire at once.
    assign match = en & (Hour == alarm_hour) & (Minute == alarm_minute) & (Second == 8'h00);

    always_comb begin
        state_nxt       = state;
        ring_cnt_nxt    = ring_cnt;
        snz_cnt_nxt     = snz_cnt;
        rep_nxt         = rep;
        start_alarm_nxt = 1'b0;
        en_nxt          = en ^ alarm_rise;

        if (en & alarm_rise) begin
            state_nxt    = IDLE;
            ring_cnt_nxt = '0;
            snz_cnt_nxt  = '0;
            rep_nxt      = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt       = RING;
                        ring_cnt_nxt    = RING_LOAD;
                        rep_nxt         = '0;
                        start_alarm_nxt = 1'b1;
                    end
                end
                RING: begin
                    // A snooze press on the final ring tick still takes effect.
                    if (snooze_rise && (rep < REP_MAX)) begin
                        state_nxt   = SNOOZE;
                        snz_cnt_nxt = SNZ_LOAD;
                        rep_nxt     = rep + PW'(1);
                    end else if (ring_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        ring_cnt_nxt = ring_cnt - RW'(1);
                    end
                end
                SNOOZE: begin
                    if (snz_cnt == '0) begin
                        state_nxt       = RING;
                        ring_cnt_nxt    = RING_LOAD;
                        start_alarm_nxt = 1'b1;
                    end else begin
                        snz_cnt_nxt = snz_cnt - SW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        active_nxt = en_nxt & (state_nxt != SNOOZE);
    end

    always_ff @(posedge CP_1Hz or negedge _CR) begin
        if (!_CR) begin
            state             <= IDLE;
            en                <= 1'b0;
            alarm_key_q       <= 1'b0;
            snooze_key_q      <= 1'b0;
            ring_cnt          <= '0;
            snz_cnt           <= '0;
            rep               <= '0;
            start_light_alarm <= 1'b0;
            active_alarm      <= 1'b0;
        end else begin
            state             <= state_nxt;
            en                <= en_nxt;
            alarm_key_q       <= alarm_key;
            snooze_key_q      <= snooze_key;
            ring_cnt          <= ring_cnt_nxt;
            snz_cnt           <= snz_cnt_nxt;
            rep               <= rep_nxt;
            start_light_alarm <= start_alarm_nxt;
            active_alarm      <= active_nxt;
        end
    end

`ifdef HOURLY_CHIME_EN
    logic [7:0] h_bin, h_mod, show_nxt;
    logic       chime;

    // Hour is at most 23, so one conditional subtract gives mod 12.
    assign h_bin    = ({4'd0, Hour[7:4]} * 8'd10) + {4'd0, Hour[3:0]};
    assign h_mod    = (h_bin >= 8'd12) ? (h_bin - 8'd12) : h_bin;
    assign show_nxt = (h_mod == 8'd0) ? 8'd24 : (h_mod << 1);
    assign chime    = (Minute == 8'h00) & (Second == 8'h00);

    always_ff @(posedge CP_1Hz or negedge _CR) begin
        if (!_CR) begin
            start_light_hour <= 1'b0;
            show_hour        <= 8'h00;
        end else begin
            start_light_hour <= chime;
            if (chime) begin
                show_hour <= show_nxt;
            end
        end
    end
`else
    assign start_light_hour = 1'b0;
    assign show_hour        = 8'h00;
`endif

endmodule
